muldiv_ctrl: RTL and testbench
==============================

Name: muldiv_ctrl

Overview:
- Multi-cycle sequencer for the MULT/MULTU/DIV/DIVU class of instructions; owns the architectural HI/LO register pair.
- The combinational ALU keeps single-cycle ops; decode issues mul/div here and stalls on busy.
- Iterative radix-2 shift-add multiply and restoring divide, fixed latency, with sign fix-up.
- Serves MFHI/MFLO from registered outputs and MTHI/MTLO writes when idle.

Parameters:
WIDTH, 32, operand width; HI/LO each WIDTH bits; iteration count = WIDTH

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous reset, active-low
start  in  1  issue request, sampled only in IDLE
op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
a  in  WIDTH  rs operand / dividend
b  in  WIDTH  rt operand / divisor
busy  out  1  high from accept edge until result write
done  out  1  one-cycle pulse after HI/LO update
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register
hi_we  in  1  MTHI write strobe
lo_we  in  1  MTLO write strobe
wdata  in  WIDTH  MTHI/MTLO data

Behaviour:
- Reset, sampled on rising clk while rst_n=0: state=IDLE, counter=0, busy=0, done=0, hi=0, lo=0. Applies mid-operation: the op is aborted and no partial result reaches HI/LO.
- States:
  - IDLE: start=1 at edge E0 latches |a|, |b| (signed ops take magnitude), op, sign_q=a[31]^b[31] and sign_r=a[31] (signed only). Clears accumulator; counter=0; -> CALC; busy=1 after E0.
  - CALC: one iteration per edge, E1..E32. Multiply: shift-add, 64-bit product. Divide: restoring shift-subtract producing quotient and remainder. counter increments; after counter=WIDTH-1 -> FIXUP.
  - FIXUP, E33:
    - Signed MULT: negate the 64-bit product if sign_q.
    - DIV: negate quotient if sign_q; negate remainder if sign_r (truncate toward zero; remainder takes the dividend's sign).
    - Writes hi=upper/remainder and lo=lower/quotient. -> IDLE; busy=0 and done=1 in the cycle after E33.
- Latency: the result is visible 33 edges after the accept edge, for every op and operand value, including the special cases.
- Divide by zero (b=0, DIV or DIVU): lo=all-ones, hi=a (original dividend, unmodified). Full latency still applies.
- Signed overflow (DIV, a=0x80000000, b=0xFFFFFFFF): lo=0x80000000, hi=0.
- start while busy is ignored; the requester must hold it until it sees busy=0.
- hi_we/lo_we:
  - In IDLE they write hi/lo from wdata at the edge. Both may be asserted together.
  - While busy they are ignored (decode stalls).
  - If start and hi_we/lo_we are asserted in the same IDLE cycle, start wins and the writes are dropped.
- hi/lo hold their value throughout CALC and change only at FIXUP, MT write, or reset.
- done stays 0 in every cycle except the single post-FIXUP cycle. busy is never 1 in IDLE.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy high 33 cycles; done pulses once; hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=0xFFFFFFFD (-3) b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Back-to-back MULTU 7x6 issued the cycle after done -> hi=0, lo=42.
- DIV a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7 b=2 -> lo=3, hi=1.
- DIV/DIVU a=0x12345678 b=0 -> lo=0xFFFFFFFF, hi=0x12345678. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0. Both at full 33-edge latency.
- MTHI 0xAAAA5555 in IDLE -> hi updates next edge.
  - hi_we during CALC, and start pulses during CALC -> ignored; result and timing unchanged.
  - start+lo_we in the same cycle -> lo ends up as the op result.
- rst_n=0 for one edge at CALC iteration 10 -> hi=lo=0, busy=0, no done pulse. A new start after reset completes normally.

Source files
------------

// File: rtl/muldiv_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | muldiv_ctrl : iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO       |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module muldiv_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata
);

   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CALC  = 2'd1,
      FIXUP = 2'd2
   } state_t;

   state_t state, state_nx;

   logic [CW-1:0]    count;
   logic             is_div;
   logic             sign_q;
   logic             sign_r;
   logic             div_zero;
   logic [WIDTH:0]   acc_hi;
   logic [WIDTH-1:0] acc_lo;
   logic [WIDTH-1:0] opnd_b;

   logic             a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH:0]   add_sum, shifted, diff, nx_hi;
   logic [WIDTH-1:0] nx_lo;
   logic [WIDTH-1:0] fix_hi, fix_lo;

   // Operand magnitudes; unsigned ops (op[0]=1) pass through untouched
   always_comb begin
      a_neg = ~op[0] & a[WIDTH-1];
      b_neg = ~op[0] & b[WIDTH-1];
      a_mag = a_neg ? -a : a;
      b_mag = b_neg ? -b : b;
   end

   // acc_hi:acc_lo is the running product (multiply) or remainder:dividend-quotient (divide)
   always_comb begin
      add_sum = acc_hi + (acc_lo[0] ? {1'b0, opnd_b} : '0);
      shifted = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
      diff    = shifted - {1'b0, opnd_b};
      if (is_div) begin
         if (diff[WIDTH]) begin
            nx_hi = shifted;
            nx_lo = {acc_lo[WIDTH-2:0], 1'b0};
         end else begin
            nx_hi = diff;
            nx_lo = {acc_lo[WIDTH-2:0], 1'b1};
         end
      end else begin
         nx_hi = {1'b0, add_sum[WIDTH:1]};
         nx_lo = {add_sum[0], acc_lo[WIDTH-1:1]};
      end
   end

   // A zero divisor leaves remainder=|a|; restoring sign_r gives back the original a
   always_comb begin
      fix_hi = acc_hi[WIDTH-1:0];
      fix_lo = acc_lo;
      if (is_div) begin
         if (div_zero) begin
            fix_lo = '1;
         end else if (sign_q) begin
            fix_lo = -acc_lo;
         end
         if (sign_r) begin
            fix_hi = -acc_hi[WIDTH-1:0];
         end
      end else if (sign_q) begin
         {fix_hi, fix_lo} = -{acc_hi[WIDTH-1:0], acc_lo};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = CALC;
         CALC:    if (count == LAST) state_nx = FIXUP;
         FIXUP:   state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count    <= '0;
         done     <= 1'b0;
         hi       <= '0;
         lo       <= '0;
         is_div   <= 1'b0;
         sign_q   <= 1'b0;
         sign_r   <= 1'b0;
         div_zero <= 1'b0;
         acc_hi   <= '0;
         acc_lo   <= '0;
         opnd_b   <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  count    <= '0;
                  is_div   <= op[1];
                  sign_q   <= a_neg ^ b_neg;
                  sign_r   <= a_neg;
                  div_zero <= op[1] & (b == '0);
                  acc_hi   <= '0;
                  acc_lo   <= a_mag;
                  opnd_b   <= b_mag;
               end else begin
                  if (hi_we) hi <= wdata;
                  if (lo_we) lo <= wdata;
               end
            end
            CALC: begin
               count  <= count + CW'(1);
               acc_hi <= nx_hi;
               acc_lo <= nx_lo;
            end
            FIXUP: begin
               hi   <= fix_hi;
               lo   <= fix_lo;
               done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
`default_nettype none
// Bench for muldiv_ctrl: vector table, corner-case sequences and random ops against a scoreboard.
module tb_muldiv_ctrl;

   localparam int W = 32;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [1:0]   op    = 2'b00;
   logic [W-1:0] a     = '0;
   logic [W-1:0] b     = '0;
   logic         hi_we = 1'b0;
   logic         lo_we = 1'b0;
   logic [W-1:0] wdata = '0;
   logic         busy, done;
   logic [W-1:0] hi, lo;

   muldiv_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo),
      .hi_we (hi_we),
      .lo_we (lo_we),
      .wdata (wdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] res;
   } vec_t;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int unsigned accept;
   } exp_t;

   vec_t        tbl[14];
   exp_t        sb[$];
   exp_t        mon_e;
   int          checks   = 0;
   int          errors   = 0;
   int unsigned edge_cnt = 0;
   int          busy_cnt = 0;
   logic        prev_done = 1'b0;
   logic [31:0] prev_hi, prev_lo;
   logic [1:0]  r_op;
   logic [31:0] r_a, r_b;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      longint p;
      int     q, r;
      if (o == 2'b00) begin
         p = longint'($signed(x)) * longint'($signed(y));
         return p;
      end
      if (o == 2'b01) return {32'b0, x} * {32'b0, y};
      if (y == 32'h0) return {x, 32'hFFFF_FFFF};
      if (o == 2'b11) return {x % y, x / y};
      if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
      q = $signed(x) / $signed(y);
      r = $signed(x) % $signed(y);
      return {r, q};
   endfunction

   // Scoreboard consumer: every done pulse must match the oldest issued op
   always @(negedge clk) begin
      if (done) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: done=1 with no op outstanding, required done=0");
         end else begin
            mon_e = sb.pop_front();
            check("result_hilo", {hi, lo}, {mon_e.hi, mon_e.lo});
            check("latency_edges", 64'(edge_cnt - mon_e.accept), 64'd33);
            check("busy_cycles", 64'(busy_cnt), 64'd33);
         end
         check("done_single_pulse", {63'b0, prev_done}, 64'd0);
         check("busy_low_at_done", {63'b0, busy}, 64'd0);
      end
      prev_done = done;
      if (!busy) busy_cnt = 0;
      else       busy_cnt++;
   end

   task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [63:0] res, input bit push);
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      if (push) sb.push_back('{res[63:32], res[31:0], edge_cnt + 1});
      @(negedge clk);
      start = 1'b0;
      check("busy_after_accept", {63'b0, busy}, 64'd1);
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while (!done && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: done=0 after %0d cycles, required 1", name, n);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1);
   end

   initial begin
      tbl[0]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
      tbl[1]  = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 64'hFFFF_FFFF_FFFF_FFF1};
      tbl[2]  = '{2'b01, 32'h0000_0007, 32'h0000_0006, 64'h0000_0000_0000_002A};
      tbl[3]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD};
      tbl[4]  = '{2'b11, 32'h0000_0007, 32'h0000_0002, 64'h0000_0001_0000_0003};
      tbl[5]  = '{2'b10, 32'h1234_5678, 32'h0000_0000, 64'h1234_5678_FFFF_FFFF};
      tbl[6]  = '{2'b11, 32'h1234_5678, 32'h0000_0000, 64'h1234_5678_FFFF_FFFF};
      tbl[7]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000};
      tbl[8]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 64'hFFFF_FFF9_FFFF_FFFF};
      tbl[9]  = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD};
      tbl[10] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
      tbl[11] = '{2'b11, 32'hFFFF_FFFF, 32'h0000_0001, 64'h0000_0000_FFFF_FFFF};
      tbl[12] = '{2'b00, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0001};
      tbl[13] = '{2'b11, 32'h0000_0064, 32'h0000_0007, 64'h0000_0002_0000_000E};

      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_hi", {32'b0, hi}, 64'd0);
      check("reset_lo", {32'b0, lo}, 64'd0);
      check("reset_busy", {63'b0, busy}, 64'd0);
      check("reset_done", {63'b0, done}, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // MTHI alone, then MTHI+MTLO together
      hi_we = 1'b1;
      wdata = 32'hAAAA_5555;
      @(negedge clk);
      hi_we = 1'b0;
      check("mthi_hi", {32'b0, hi}, 64'h0000_0000_AAAA_5555);
      check("mthi_lo_untouched", {32'b0, lo}, 64'd0);
      hi_we = 1'b1;
      lo_we = 1'b1;
      wdata = 32'h1357_9BDF;
      @(negedge clk);
      hi_we = 1'b0;
      lo_we = 1'b0;
      check("mt_both", {hi, lo}, 64'h1357_9BDF_1357_9BDF);

      // Vector table; each op is issued in the done cycle of the previous one
      for (int i = 0; i < 14; i++) begin
         issue(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res, 1'b1);
         wait_done("table");
      end

      // start together with MTLO: start wins, lo untouched until the result lands
      prev_lo = lo;
      lo_we   = 1'b1;
      wdata   = 32'h0000_5555;
      issue(2'b11, 32'h0000_0064, 32'h0000_0007, 64'h0000_0002_0000_000E, 1'b1);
      lo_we   = 1'b0;
      check("start_wins_over_mtlo", {32'b0, lo}, {32'b0, prev_lo});
      wait_done("start_mtlo");

      // MT writes and extra start pulses in CALC are ignored
      prev_hi = hi;
      prev_lo = lo;
      issue(2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 64'hFFFF_FFFF_FFFF_FFF1, 1'b1);
      repeat (5) @(negedge clk);
      hi_we = 1'b1;
      lo_we = 1'b1;
      wdata = 32'hDEAD_BEEF;
      start = 1'b1;
      op    = 2'b11;
      a     = 32'h1;
      b     = 32'h1;
      repeat (3) @(negedge clk);
      hi_we = 1'b0;
      lo_we = 1'b0;
      start = 1'b0;
      check("hold_during_calc", {hi, lo}, {prev_hi, prev_lo});
      wait_done("calc_ignore");

      // Reset mid-CALC aborts the op with no done and no partial result
      issue(2'b10, 32'h0000_0064, 32'h0000_0007, 64'h0, 1'b0);
      repeat (9) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("abort_hilo", {hi, lo}, 64'd0);
      check("abort_busy", {63'b0, busy}, 64'd0);
      repeat (40) @(negedge clk);
      check("abort_stays_idle", {63'b0, busy}, 64'd0);
      issue(2'b01, 32'h0000_0007, 32'h0000_0006, 64'h0000_0000_0000_002A, 1'b1);
      wait_done("after_reset");

      // Random ops against the reference model
      for (int i = 0; i < 20; i++) begin
         r_op = 2'($urandom_range(0, 3));
         r_a  = $urandom;
         case ($urandom_range(0, 3))
            0:       r_b = 32'h0;
            1:       r_b = $urandom >> $urandom_range(16, 31);
            default: r_b = $urandom;
         endcase
         issue(r_op, r_a, r_b, model(r_op, r_a, r_b), 1'b1);
         wait_done("random");
      end

      repeat (3) @(negedge clk);
      check("scoreboard_drained", 64'(sb.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
